// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single DataMemory port between the pipeline MEM stage (CPU)
//   and an external loader/debug port (LDR).
//   Each cycle the arbiter grants the memory to at most one requester:
//     - the CPU has priority in normal sharing mode,
//     - a starvation guard forces the LDR to win after STARVE_MAX
//       consecutive refused cycles,
//     - the LDR can take exclusive ownership through LdrLock. The lock is
//       acquired only once the CPU is idle, so a CPU access in flight is
//       never cut short.
//
// Ports
//   Clk, Reset             clock, synchronous active-low reset
//   Cpu* (in)              CPU request, direction, address, data, size
//   CpuRData, CpuStall     CPU read data (combinational), pipeline hold
//   Ldr* (in)              loader request, direction, address, data, lock
//   LdrAck                 loader access performed this cycle
//   LdrRData, LdrRValid    registered loader read data and its valid pulse
//   LdrLocked              memory is exclusively owned by the loader
//   Mem* (out), MemRData   DataMemory port (combinational read)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX   = 4,
  parameter logic [1:0]  LDR_MEM_TYPE = 2'b00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CpuReq,
  input  logic        CpuWe,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWData,
  input  logic [1:0]  CpuType,
  output logic [31:0] CpuRData,
  output logic        CpuStall,
  input  logic        LdrReq,
  input  logic        LdrWe,
  input  logic [31:0] LdrAddr,
  input  logic [31:0] LdrWData,
  input  logic        LdrLock,
  output logic        LdrAck,
  output logic [31:0] LdrRData,
  output logic        LdrRValid,
  output logic        LdrLocked,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [1:0]  MemType,
  input  logic [31:0] MemRData
);

  localparam logic [1:0] ST_SHARE     = 2'd0;
  localparam logic [1:0] ST_LOCK_PEND = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] ldr_rdata_q, ldr_rdata_d;
  logic        ldr_rvalid_q, ldr_rvalid_d;

  logic        cpu_win_s;
  logic        ldr_win_s;

  // Per-cycle grant; nobody wins while reset is held so memory sees no access.
  always_comb begin
    cpu_win_s = 1'b0;
    ldr_win_s = 1'b0;
    if (Reset) begin
      case (state_q)
        ST_SHARE: begin
          cpu_win_s = CpuReq & (starve_cnt_q < STARVE_LIM);
          ldr_win_s = LdrReq & ~cpu_win_s;
        end
        ST_LOCK_PEND: begin
          // Lock is waiting for the CPU to go idle; CPU keeps priority.
          cpu_win_s = CpuReq;
          ldr_win_s = LdrReq & ~CpuReq;
        end
        ST_LOCKED: begin
          cpu_win_s = 1'b0;
          ldr_win_s = LdrReq;
        end
        default: begin
          cpu_win_s = 1'b0;
          ldr_win_s = 1'b0;
        end
      endcase
    end else begin
      cpu_win_s = 1'b0;
      ldr_win_s = 1'b0;
    end
  end

  // Memory port mux; with no winner the address/data lines stay on the CPU.
  always_comb begin
    if (ldr_win_s) begin
      MemAddr  = LdrAddr;
      MemWData = LdrWData;
    end else begin
      MemAddr  = CpuAddr;
      MemWData = CpuWData;
    end
    if (cpu_win_s) begin
      MemType = CpuType;
    end else begin
      MemType = LDR_MEM_TYPE;
    end
    MemWrite = (cpu_win_s & CpuWe) | (ldr_win_s & LdrWe);
    MemRead  = (cpu_win_s & ~CpuWe) | (ldr_win_s & ~LdrWe);
  end

  assign CpuRData  = MemRData;
  assign CpuStall  = Reset & CpuReq & ~cpu_win_s;
  assign LdrAck    = ldr_win_s;
  assign LdrRData  = ldr_rdata_q;
  assign LdrRValid = ldr_rvalid_q;
  assign LdrLocked = (state_q == ST_LOCKED);

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SHARE: begin
        if (LdrLock) begin
          state_d = ST_LOCK_PEND;
        end else begin
          state_d = ST_SHARE;
        end
      end
      ST_LOCK_PEND: begin
        // Dropping the lock request takes precedence over acquiring it.
        if (!LdrLock) begin
          state_d = ST_SHARE;
        end else if (!CpuReq) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_LOCK_PEND;
        end
      end
      ST_LOCKED: begin
        if (!LdrLock) begin
          state_d = ST_SHARE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SHARE;
      end
    endcase
  end

  // Starvation counter: counts consecutive refused LDR cycles, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ldr_win_s) begin
      starve_cnt_d = 4'd0;
    end else if (LdrReq) begin
      if (starve_cnt_q >= STARVE_LIM) begin
        starve_cnt_d = STARVE_LIM;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end
  end

  // LDR read return: capture memory data at the edge ending a granted LDR read.
  always_comb begin
    ldr_rvalid_d = ldr_win_s & ~LdrWe;
    if (ldr_rvalid_d) begin
      ldr_rdata_d = MemRData;
    end else begin
      ldr_rdata_d = ldr_rdata_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= ST_SHARE;
      starve_cnt_q <= 4'd0;
      ldr_rdata_q  <= 32'd0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ldr_rdata_q  <= ldr_rdata_d;
      ldr_rvalid_q <= ldr_rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter: a directed vector table, hand-written sequences
//   for reset-during-lock and loader bursts, then randomized traffic. A
//   behavioural model (ownership mode, refusal count, shadow memory) predicts
//   every output each cycle; a simple word memory stands in for DataMemory.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int SMAX = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWe;
  logic [31:0] CpuAddr, CpuWData;
  logic [1:0]  CpuType;
  logic [31:0] CpuRData;
  logic        CpuStall;
  logic        LdrReq, LdrWe;
  logic [31:0] LdrAddr, LdrWData;
  logic        LdrLock;
  logic        LdrAck;
  logic [31:0] LdrRData;
  logic        LdrRValid, LdrLocked;
  logic [31:0] MemAddr, MemWData;
  logic        MemWrite, MemRead;
  logic [1:0]  MemType;
  logic [31:0] MemRData;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.STARVE_MAX(SMAX), .LDR_MEM_TYPE(2'b00)) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuType(CpuType), .CpuRData(CpuRData), .CpuStall(CpuStall),
    .LdrReq(LdrReq), .LdrWe(LdrWe), .LdrAddr(LdrAddr), .LdrWData(LdrWData),
    .LdrLock(LdrLock), .LdrAck(LdrAck), .LdrRData(LdrRData),
    .LdrRValid(LdrRValid), .LdrLocked(LdrLocked),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemType(MemType), .MemRData(MemRData)
  );

  // DataMemory stand-in: 256 words, combinational read, write at the edge.
  logic [31:0] dmem [0:255];
  assign MemRData = dmem[MemAddr[9:2]];
  always @(posedge Clk) if (MemWrite) dmem[MemAddr[9:2]] <= MemWData;

  // Behavioural model state.
  int          m_mode;     // 0 shared, 1 lock requested, 2 loader owns memory
  int          m_refused;  // consecutive cycles the loader asked and was refused
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          m_last_lw;
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Who should own the port this cycle.
  task automatic grants(output bit cw, output bit lw);
    cw = 1'b0;
    lw = 1'b0;
    if (Reset === 1'b1) begin
      if (m_mode == 0) begin
        // Loader forced through once it has been refused SMAX times in a row.
        cw = CpuReq && (m_refused < SMAX);
        lw = LdrReq && !cw;
      end else if (m_mode == 1) begin
        cw = CpuReq;
        lw = LdrReq && !CpuReq;
      end else begin
        lw = LdrReq;
      end
    end
  endtask

  task automatic model_check();
    bit cw, lw;
    grants(cw, lw);
    chk1("CpuStall", CpuStall, (Reset === 1'b1) && CpuReq && !cw);
    chk1("LdrAck", LdrAck, lw);
    chk1("MemWrite", MemWrite, (cw && CpuWe) || (lw && LdrWe));
    chk1("MemRead", MemRead, (cw && !CpuWe) || (lw && !LdrWe));
    chk("MemAddr", MemAddr, lw ? LdrAddr : CpuAddr);
    chk("MemWData", MemWData, lw ? LdrWData : CpuWData);
    chk("MemType", {30'd0, MemType}, {30'd0, (cw ? CpuType : 2'b00)});
    chk1("LdrLocked", LdrLocked, m_mode == 2);
    chk1("LdrRValid", LdrRValid, m_rvalid);
    chk("LdrRData", LdrRData, m_rdata);
    if (cw && !CpuWe) chk("CpuRData", CpuRData, ref_mem[CpuAddr[9:2]]);
  endtask

  // Called right after a rising edge, before inputs change.
  task automatic model_update();
    bit cw, lw;
    grants(cw, lw);
    m_last_lw = lw;
    if (Reset !== 1'b1) begin
      m_mode = 0; m_refused = 0; m_rvalid = 1'b0; m_rdata = 32'd0;
    end else begin
      m_rvalid = lw && !LdrWe;
      if (m_rvalid) m_rdata = ref_mem[LdrAddr[9:2]];
      if (cw && CpuWe) ref_mem[CpuAddr[9:2]] = CpuWData;
      if (lw && LdrWe) ref_mem[LdrAddr[9:2]] = LdrWData;
      if (lw || !LdrReq) m_refused = 0;
      else if (m_refused < SMAX) m_refused++;
      case (m_mode)
        0: if (LdrLock) m_mode = 1;
        1: if (!LdrLock) m_mode = 0; else if (!CpuReq) m_mode = 2;
        default: if (!LdrLock) m_mode = 0;
      endcase
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic lk);
    CpuReq = cr; CpuWe = cw; CpuAddr = ca; CpuWData = cd; CpuType = 2'b10;
    LdrReq = lr; LdrWe = lw; LdrAddr = la; LdrWData = ld; LdrLock = lk;
  endtask

  task automatic settle();
    @(negedge Clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  typedef struct packed {
    logic cr, cw; logic [31:0] ca, cd;
    logic lr, lw; logic [31:0] la, ld; logic lk;
    logic e_stall, e_ack, e_mw, e_mr, e_rv, e_lk;
    logic c_crd; logic [31:0] e_crd;
    logic c_lrd; logic [31:0] e_lrd;
  } vec_t;

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic lr, logic lw, logic [31:0] la, logic [31:0] ld, logic lk,
                              logic [5:0] e, logic c_crd, logic [31:0] e_crd,
                              logic c_lrd, logic [31:0] e_lrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lw = lw; v.la = la; v.ld = ld; v.lk = lk;
    {v.e_stall, v.e_ack, v.e_mw, v.e_mr, v.e_rv, v.e_lk} = e;
    v.c_crd = c_crd; v.e_crd = e_crd; v.c_lrd = c_lrd; v.e_lrd = e_lrd;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    bit ldr_pend;

    // Expected flags: {stall, ack, mwrite, mread, rvalid, locked}
    tbl[0]  = mk(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'b000100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 6'b011000, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 3; i <= 6; i++)
      tbl[i] = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 6'b000100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 6'b111000, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[8]  = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 6'b000100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 6'b010100, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'b000010, 1'b0, 32'h0, 1'b1, 32'h12345678);
    tbl[11] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b1, 32'h12345678);
    tbl[12] = mk(1'b1, 1'b1, 32'h50, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'b001000, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[13] = mk(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'b000100, 1'b1, 32'h11111111, 1'b0, 32'h0);
    tbl[14] = mk(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'b000100, 1'b1, 32'h11111111, 1'b0, 32'h0);
    tbl[15] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[16] = mk(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'b100001, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[17] = mk(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 32'h60, 32'h22222222, 1'b1, 6'b111001, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[18] = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'b100001, 1'b0, 32'h0, 1'b0, 32'h0);
    tbl[19] = mk(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'b000100, 1'b1, 32'h22222222, 1'b0, 32'h0);

    for (int i = 0; i < 256; i++) begin
      dmem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    m_mode = 0; m_refused = 0; m_rvalid = 1'b0; m_rdata = 32'd0; m_last_lw = 1'b0;

    // Reset: first edge initialises the flops, then reset state is checked.
    Reset = 1'b0;
    drive(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h0, 1'b1);
    tick();
    settle();
    chk1("reset_no_write", MemWrite, 1'b0);
    chk1("reset_no_stall", CpuStall, 1'b0);
    chk1("reset_locked", LdrLocked, 1'b0);
    chk("reset_ldr_rdata", LdrRData, 32'd0);
    tick();
    Reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].lr, tbl[i].lw, tbl[i].la, tbl[i].ld, tbl[i].lk);
      settle();
      chk1($sformatf("v%0d_stall", i), CpuStall, tbl[i].e_stall);
      chk1($sformatf("v%0d_ack", i), LdrAck, tbl[i].e_ack);
      chk1($sformatf("v%0d_mwrite", i), MemWrite, tbl[i].e_mw);
      chk1($sformatf("v%0d_mread", i), MemRead, tbl[i].e_mr);
      chk1($sformatf("v%0d_rvalid", i), LdrRValid, tbl[i].e_rv);
      chk1($sformatf("v%0d_locked", i), LdrLocked, tbl[i].e_lk);
      if (tbl[i].c_crd) chk($sformatf("v%0d_cpu_rdata", i), CpuRData, tbl[i].e_crd);
      if (tbl[i].c_lrd) chk($sformatf("v%0d_ldr_rdata", i), LdrRData, tbl[i].e_lrd);
      tick();
    end

    // Reset while locked, with a loader read result pending and a write requested.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    settle(); tick();
    settle(); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    settle();
    chk1("t5_locked_read_ack", LdrAck, 1'b1);
    tick();
    Reset = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h30, 32'h99, 1'b1);
    settle();
    chk1("t5_reset_mwrite", MemWrite, 1'b0);
    chk1("t5_reset_ack", LdrAck, 1'b0);
    chk1("t5_reset_stall", CpuStall, 1'b0);
    tick();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    settle();
    chk1("t5_after_locked", LdrLocked, 1'b0);
    chk1("t5_after_rvalid", LdrRValid, 1'b0);
    chk("t5_after_rdata", LdrRData, 32'd0);
    chk("t5_no_write_0x30", dmem[12], 32'd0);
    tick();

    // Loader burst of 8 writes, then CPU reads them back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 1'b0);
      settle();
      chk1($sformatf("t6_ack%0d", i), LdrAck, 1'b1);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      settle();
      chk($sformatf("t6_rd%0d", i), CpuRData, 32'hC0DE0000 + 32'(i));
      tick();
    end

    // Randomized traffic; the loader holds each request until acknowledged.
    ldr_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      Reset    = ($urandom_range(0, 149) != 0);
      CpuReq   = ($urandom_range(0, 2) != 0);
      CpuWe    = $urandom_range(0, 1) != 0;
      CpuAddr  = 32'($urandom_range(0, 63)) << 2;
      CpuWData = $urandom;
      CpuType  = 2'($urandom_range(0, 3));
      if (!ldr_pend && ($urandom_range(0, 1) != 0)) begin
        ldr_pend = 1'b1;
        LdrWe    = $urandom_range(0, 1) != 0;
        LdrAddr  = 32'($urandom_range(0, 63)) << 2;
        LdrWData = $urandom;
      end
      LdrReq = ldr_pend;
      if ($urandom_range(0, 15) == 0) LdrLock = ~LdrLock;
      settle();
      tick();
      if (m_last_lw) ldr_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
